alu_arbiter: RTL and testbench

ALU_ARBITER -- requirements
Module: alu_arbiter

---
 rtl/alu_arbiter.sv | 178 +++++++++++++++++
 tb/tb_alu_arbiter.sv | 318 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/alu_arbiter.sv
// alu_arbiter: two requesters share one ALU. One operation is in flight at a time.
//
// Handshakes follow strict valid/ready semantics. A transfer happens on a rising
// edge where valid and ready are both high. A requester holds valid and its
// operands stable until it sees ready. reqX_ready is combinational from the
// valids and is never high unless the matching valid is high. The consumer may
// assert rsp_ready at any time. rsp_id/result/carry/err hold their values while
// rsp_valid is high and rsp_ready is low.
//
// Ports:
//   clk, rst                    clock, synchronous active-high reset
//   req0_*/req1_*               valid, ready, operands a/b (N bits), op (4 bits)
//   rsp_valid, rsp_ready        response handshake
//   rsp_id                      requester that owns the response
//   rsp_result (2N)             zero-extended result; full product for mul
//   rsp_carry, rsp_err          add carry / sub borrow; div-by-zero or bad opcode
//   busy                        FSM is not in IDLE
//   state_dbg                   current FSM state (debug visibility)

module alu #(
  parameter int N = 4
) (
  input  logic [3:0]     op,
  input  logic [N-1:0]   a,
  input  logic [N-1:0]   b,
  output logic [2*N-1:0] result,
  output logic           carry,
  output logic           err
);
  logic [N:0] sum;
  logic [N:0] diff;

  assign sum  = {1'b0, a} + {1'b0, b};
  // Bit N of the extended difference is set exactly when a < b (borrow).
  assign diff = {1'b0, a} - {1'b0, b};

  always_comb begin
    result = '0;
    carry  = 1'b0;
    err    = 1'b0;
    case (op)
      4'd0: begin result = {{N{1'b0}}, sum[N-1:0]};  carry = sum[N];  end
      4'd1: begin result = {{N{1'b0}}, diff[N-1:0]}; carry = diff[N]; end
      4'd2: result = {{N{1'b0}}, a} * {{N{1'b0}}, b};
      4'd3: begin
        if (b == '0) begin
          result = {{N{1'b0}}, {N{1'b1}}};
          err    = 1'b1;
        end else begin
          result = {{N{1'b0}}, a / b};
        end
      end
      4'd4: begin
        if (b == '0) begin
          result = {{N{1'b0}}, {N{1'b1}}};
          err    = 1'b1;
        end else begin
          result = {{N{1'b0}}, a % b};
        end
      end
      4'd5: result = {{N{1'b0}}, a & b};
      4'd6: result = {{N{1'b0}}, a | b};
      4'd7: result = {{N{1'b0}}, a ^ b};
      4'd8: result = {{N{1'b0}}, a[N-2:0], 1'b0};
      default: err = 1'b1;
    endcase
  end
endmodule

module alu_arbiter #(
  parameter int N = 4
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           req0_valid,
  output logic           req0_ready,
  input  logic [N-1:0]   req0_a,
  input  logic [N-1:0]   req0_b,
  input  logic [3:0]     req0_op,
  input  logic           req1_valid,
  output logic           req1_ready,
  input  logic [N-1:0]   req1_a,
  input  logic [N-1:0]   req1_b,
  input  logic [3:0]     req1_op,
  output logic           rsp_valid,
  input  logic           rsp_ready,
  output logic           rsp_id,
  output logic [2*N-1:0] rsp_result,
  output logic           rsp_carry,
  output logic           rsp_err,
  output logic           busy,
  output logic [1:0]     state_dbg
);
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    RESP = 2'd2
  } state_t;

  state_t state, state_nx;

  // 1 means requester 1 was granted most recently. The reset value lets
  // requester 0 win the first tie.
  logic           last_grant;
  logic           grant0, grant1;
  logic [N-1:0]   a_q, b_q;
  logic [3:0]     op_q;
  logic           id_q;
  logic [2*N-1:0] alu_result;
  logic           alu_carry, alu_err;

  alu #(.N(N)) u_alu (
    .op     (op_q),
    .a      (a_q),
    .b      (b_q),
    .result (alu_result),
    .carry  (alu_carry),
    .err    (alu_err)
  );

  always_comb begin
    state_nx = state;
    grant0   = 1'b0;
    grant1   = 1'b0;
    case (state)
      IDLE: begin
        if (!rst) begin
          // A lone requester always wins. On a tie, grant the one not granted last.
          if (req0_valid && (!req1_valid || last_grant)) begin
            grant0 = 1'b1;
          end else if (req1_valid) begin
            grant1 = 1'b1;
          end
          if (grant0 || grant1) state_nx = EXEC;
        end
      end
      EXEC:    state_nx = RESP;
      RESP:    if (rsp_ready) state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      last_grant <= 1'b1;
      a_q        <= '0;
      b_q        <= '0;
      op_q       <= '0;
      id_q       <= 1'b0;
      rsp_result <= '0;
      rsp_carry  <= 1'b0;
      rsp_err    <= 1'b0;
    end else begin
      state <= state_nx;
      // A grant is only issued for a valid requester, so a grant is a completed handshake.
      if (grant0 || grant1) begin
        a_q        <= grant1 ? req1_a  : req0_a;
        b_q        <= grant1 ? req1_b  : req0_b;
        op_q       <= grant1 ? req1_op : req0_op;
        id_q       <= grant1;
        last_grant <= grant1;
      end
      if (state == EXEC) begin
        rsp_result <= alu_result;
        rsp_carry  <= alu_carry;
        rsp_err    <= alu_err;
      end
    end
  end

  assign req0_ready = grant0;
  assign req1_ready = grant1;
  assign rsp_valid  = (state == RESP);
  assign rsp_id     = id_q;
  assign busy       = (state != IDLE);
  assign state_dbg  = state;
endmodule

// File: tb/tb_alu_arbiter.sv
module tb_alu_arbiter;
  localparam int N = 4;
  localparam int W = 2 * N + 3;  // {id, carry, err, result}

  logic           clk = 1'b0;
  logic           rst;
  logic           req0_valid, req0_ready, req1_valid, req1_ready;
  logic [N-1:0]   req0_a, req0_b, req1_a, req1_b;
  logic [3:0]     req0_op, req1_op;
  logic           rsp_valid, rsp_ready, rsp_id, rsp_carry, rsp_err, busy;
  logic [2*N-1:0] rsp_result;
  logic [1:0]     state_dbg;

  alu_arbiter #(.N(N)) dut (
    .clk        (clk),
    .rst        (rst),
    .req0_valid (req0_valid),
    .req0_ready (req0_ready),
    .req0_a     (req0_a),
    .req0_b     (req0_b),
    .req0_op    (req0_op),
    .req1_valid (req1_valid),
    .req1_ready (req1_ready),
    .req1_a     (req1_a),
    .req1_b     (req1_b),
    .req1_op    (req1_op),
    .rsp_valid  (rsp_valid),
    .rsp_ready  (rsp_ready),
    .rsp_id     (rsp_id),
    .rsp_result (rsp_result),
    .rsp_carry  (rsp_carry),
    .rsp_err    (rsp_err),
    .busy       (busy),
    .state_dbg  (state_dbg)
  );

  // Clock / reset block
  always #5 clk = ~clk;

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // Scoreboard and reference model state
  int checks   = 0;
  int failures = 0;
  logic [W-1:0] exp_q[$];
  logic [W-1:0] got_q[$];
  bit flight = 1'b0;  // an accepted request has not yet had its response consumed
  int age    = 0;     // cycles since acceptance while in flight
  bit last   = 1'b1;  // requester granted most recently
  bit hs     = 1'b0;  // a request handshake happened in the last step
  bit hs_id  = 1'b0;

  typedef struct {
    logic           id;
    logic [3:0]     op;
    logic [N-1:0]   a;
    logic [N-1:0]   b;
    logic [2*N-1:0] res;
    logic           c;
    logic           e;
  } vec_t;
  vec_t vt[15];

  task automatic chk(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Reference model computed from the arithmetic definition of each opcode.
  function automatic logic [W-1:0] model(input bit id, input int op, input int a, input int b);
    int m;
    int r;
    bit c;
    bit e;
    m = 1 << N;
    r = 0;
    c = 1'b0;
    e = 1'b0;
    case (op)
      0: begin r = (a + b) % m; c = (a + b) >= m; end
      1: begin r = (a - b + m) % m; c = a < b; end
      2: r = a * b;
      3: if (b == 0) begin r = m - 1; e = 1'b1; end else r = a / b;
      4: if (b == 0) begin r = m - 1; e = 1'b1; end else r = a % b;
      5: r = a & b;
      6: r = a | b;
      7: r = a ^ b;
      8: r = (a * 2) % m;
      default: e = 1'b1;
    endcase
    return {id, c, e, r[2*N-1:0]};
  endfunction

  // One clock cycle: sample and check at negedge+2, advance the model, wait for the next negedge.
  task automatic step();
    bit g0;
    bit g1;
    #2;
    g0 = 1'b0;
    g1 = 1'b0;
    if (!rst && !flight) begin
      if (req0_valid && req1_valid) begin
        g0 = last;
        g1 = !last;
      end else begin
        g0 = req0_valid;
        g1 = req1_valid;
      end
    end
    chk("req0_ready", W'(req0_ready), W'(g0));
    chk("req1_ready", W'(req1_ready), W'(g1));
    chk("busy", W'(busy), W'(flight && age >= 1));
    chk("rsp_valid", W'(rsp_valid), W'(flight && age >= 2));
    if (flight && age >= 2 && rsp_valid && exp_q.size() > 0)
      chk("rsp_fields", {rsp_id, rsp_carry, rsp_err, rsp_result}, exp_q[0]);
    hs = 1'b0;
    if (rst) begin
      flight = 1'b0;
      exp_q.delete();
      last = 1'b1;
    end else if (flight) begin
      if (age >= 2 && rsp_ready) begin
        flight = 1'b0;
        got_q.push_back({rsp_id, rsp_carry, rsp_err, rsp_result});
        if (exp_q.size() > 0) void'(exp_q.pop_front());
      end else begin
        age++;
      end
    end else if (g0 || g1) begin
      hs    = 1'b1;
      hs_id = g1;
      last  = g1;
      if (g1) exp_q.push_back(model(1'b1, int'(req1_op), int'(req1_a), int'(req1_b)));
      else    exp_q.push_back(model(1'b0, int'(req0_op), int'(req0_a), int'(req0_b)));
      flight = 1'b1;
      age    = 1;
    end
    @(negedge clk);
  endtask

  // Driver tasks
  task automatic issue(input bit id, input logic [3:0] op, input logic [N-1:0] a, input logic [N-1:0] b);
    int n;
    n = 0;
    if (id) begin req1_valid = 1'b1; req1_op = op; req1_a = a; req1_b = b; end
    else    begin req0_valid = 1'b1; req0_op = op; req0_a = a; req0_b = b; end
    hs = 1'b0;
    while (!hs && n < 20) begin
      step();
      n++;
    end
    if (id) req1_valid = 1'b0;
    else    req0_valid = 1'b0;
    if (!hs) begin
      checks++;
      failures++;
      $display("FAIL issue_timeout: got no handshake expected handshake within 20 cycles");
    end
  endtask

  task automatic drain();
    int n;
    n = 0;
    while (flight && n < 30) begin
      step();
      n++;
    end
    if (flight) begin
      checks++;
      failures++;
      $display("FAIL drain_timeout: got no response expected response within 30 cycles");
    end
  endtask

  task automatic do_reset();
    rst = 1'b1;
    step();
    rst = 1'b0;
  endtask

  initial begin
    rst = 1'b1;
    req0_valid = 1'b0; req1_valid = 1'b0;
    req0_a = '0; req0_b = '0; req0_op = '0;
    req1_a = '0; req1_b = '0; req1_op = '0;
    rsp_ready = 1'b1;

    vt[0]  = '{1'b0, 4'd0,  4'd9,  4'd8,  8'h01, 1'b1, 1'b0};
    vt[1]  = '{1'b1, 4'd3,  4'd7,  4'd0,  8'h0F, 1'b0, 1'b1};
    vt[2]  = '{1'b1, 4'd4,  4'd7,  4'd3,  8'h01, 1'b0, 1'b0};
    vt[3]  = '{1'b0, 4'd12, 4'd5,  4'd5,  8'h00, 1'b0, 1'b1};
    vt[4]  = '{1'b0, 4'd1,  4'd3,  4'd5,  8'h0E, 1'b1, 1'b0};
    vt[5]  = '{1'b1, 4'd2,  4'd15, 4'd15, 8'hE1, 1'b0, 1'b0};
    vt[6]  = '{1'b0, 4'd5,  4'hC,  4'hA,  8'h08, 1'b0, 1'b0};
    vt[7]  = '{1'b1, 4'd6,  4'hC,  4'hA,  8'h0E, 1'b0, 1'b0};
    vt[8]  = '{1'b0, 4'd7,  4'hC,  4'hA,  8'h06, 1'b0, 1'b0};
    vt[9]  = '{1'b1, 4'd8,  4'd9,  4'd0,  8'h02, 1'b0, 1'b0};
    vt[10] = '{1'b0, 4'd0,  4'd7,  4'd8,  8'h0F, 1'b0, 1'b0};
    vt[11] = '{1'b1, 4'd1,  4'd5,  4'd5,  8'h00, 1'b0, 1'b0};
    vt[12] = '{1'b0, 4'd3,  4'd15, 4'd4,  8'h03, 1'b0, 1'b0};
    vt[13] = '{1'b1, 4'd15, 4'd3,  4'd3,  8'h00, 1'b0, 1'b1};
    vt[14] = '{1'b0, 4'd8,  4'hF,  4'd0,  8'h0E, 1'b0, 1'b0};

    @(negedge clk);
    @(negedge clk);
    // Ready must stay low while reset is held, even with both valids high.
    req0_valid = 1'b1; req1_valid = 1'b1;
    step();
    req0_valid = 1'b0; req1_valid = 1'b0;
    chk("reset_rsp_id", W'(rsp_id), W'(1'b0));
    chk("reset_rsp_result", W'(rsp_result), W'(0));
    chk("reset_rsp_carry", W'(rsp_carry), W'(1'b0));
    chk("reset_rsp_err", W'(rsp_err), W'(1'b0));
    rst = 1'b0;

    // Table-driven single-requester vectors
    for (int i = 0; i < 15; i++) begin
      got_q.delete();
      issue(vt[i].id, vt[i].op, vt[i].a, vt[i].b);
      drain();
      if (got_q.size() == 1)
        chk($sformatf("table_%0d", i), got_q[0], {vt[i].id, vt[i].c, vt[i].e, vt[i].res});
      else
        chk($sformatf("table_%0d_count", i), W'(got_q.size()), W'(1));
    end

    // Tie after reset: requester 0 first, then requester 1
    do_reset();
    got_q.delete();
    req0_valid = 1'b1; req0_op = 4'd2; req0_a = 4'd15; req0_b = 4'd15;
    req1_valid = 1'b1; req1_op = 4'd1; req1_a = 4'd3;  req1_b = 4'd5;
    for (int n = 0; n < 30 && got_q.size() < 2; n++) begin
      step();
      if (hs) begin
        if (hs_id) req1_valid = 1'b0;
        else       req0_valid = 1'b0;
      end
    end
    req0_valid = 1'b0; req1_valid = 1'b0;
    chk("tie_count", W'(got_q.size()), W'(2));
    if (got_q.size() >= 2) begin
      chk("tie_first", got_q[0], {1'b0, 1'b0, 1'b0, 8'hE1});
      chk("tie_second", got_q[1], {1'b1, 1'b1, 1'b0, 8'h0E});
    end

    // Consumer stalls in RESP for 5 cycles with both requesters waiting
    rsp_ready = 1'b0;
    issue(1'b0, 4'd0, 4'd9, 4'd8);
    step();
    req0_valid = 1'b1; req1_valid = 1'b1;
    for (int n = 0; n < 5; n++) step();
    rsp_ready = 1'b1;
    step();
    req0_valid = 1'b0; req1_valid = 1'b0;
    step();
    chk("stall_idle_after_release", W'(busy), W'(1'b0));

    // Illegal opcode, then reset during EXEC of a second request
    issue(1'b0, 4'd12, 4'd6, 4'd2);
    drain();
    issue(1'b1, 4'd0, 4'd1, 4'd2);
    rst = 1'b1;
    req0_valid = 1'b1;
    step();
    rst = 1'b0;
    req0_valid = 1'b0;
    for (int n = 0; n < 4; n++) step();

    // Continuous contention: grants alternate starting from requester 0
    do_reset();
    got_q.delete();
    req0_valid = 1'b1; req0_op = 4'd0; req0_a = 4'd1; req0_b = 4'd2;
    req1_valid = 1'b1; req1_op = 4'd7; req1_a = 4'd5; req1_b = 4'd3;
    for (int n = 0; n < 60 && got_q.size() < 6; n++) step();
    req0_valid = 1'b0; req1_valid = 1'b0;
    chk("alt_count", W'(got_q.size()), W'(6));
    for (int i = 0; i < 6 && i < got_q.size(); i++)
      chk($sformatf("alt_grant_%0d", i), W'(got_q[i][W-1]), W'(i % 2));

    // Randomized traffic against the reference model
    for (int i = 0; i < 500; i++) begin
      if (!req0_valid && $urandom_range(0, 2) == 0) begin
        req0_valid = 1'b1;
        req0_op = 4'($urandom_range(0, 15));
        req0_a  = N'($urandom);
        req0_b  = N'($urandom);
      end
      if (!req1_valid && $urandom_range(0, 2) == 0) begin
        req1_valid = 1'b1;
        req1_op = 4'($urandom_range(0, 15));
        req1_a  = N'($urandom);
        req1_b  = N'($urandom);
      end
      rsp_ready = ($urandom_range(0, 3) != 0);
      rst = ($urandom_range(0, 60) == 0);
      step();
      if (hs) begin
        if (hs_id) req1_valid = 1'b0;
        else       req0_valid = 1'b0;
      end
    end
    rst = 1'b0;
    req0_valid = 1'b0; req1_valid = 1'b0;
    rsp_ready = 1'b1;
    drain();
    step();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
